rf_scoreboard_ctrl: RTL and testbench
=====================================

RF_SCOREBOARD_CTRL -- requirements
Module: rf_scoreboard_ctrl

Interface
REQ-001 SHALL take parameters: ADDR_WIDTH, default 5, register address width; WORD_WIDTH, default 32, data width; N_OF_REGS, default 32, register count.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-003 SHALL have issue_valid_i  input  1  issue stage presents an instruction.
REQ-004 SHALL have issue_rs1_i, issue_rs2_i, issue_rd_i  input  ADDR_WIDTH each  source and destination register addresses.
REQ-005 SHALL have issue_rd_en_i  input  1  instruction writes rd.
REQ-006 SHALL have issue_ready_o  output  1  no hazard, instruction may issue.
REQ-007 SHALL have alu_wb_valid_i  input  1, alu_wb_addr_i  input  ADDR_WIDTH, alu_wb_data_i  input  WORD_WIDTH, alu_wb_ready_o  output  1  ALU writeback request channel.
REQ-008 SHALL have lsu_wb_valid_i  input  1, lsu_wb_addr_i  input  ADDR_WIDTH, lsu_wb_data_i  input  WORD_WIDTH, lsu_wb_ready_o  output  1  LSU writeback request channel.
REQ-009 SHALL have rf_wen_o  output  1, rf_addr_wd_o  output  ADDR_WIDTH, rf_wd_o  output  WORD_WIDTH  register-bank write port drive.
REQ-010 SHALL have flush_i  input  1  pipeline flush.
REQ-011 SHALL have busy_o  output  N_OF_REGS  scoreboard state; wb_err_o  output  1  writeback to non-busy register.

Function
REQ-012 SHALL hold one busy bit per register; busy[0] is constant 0.
REQ-013 SHALL drive issue_ready_o combinationally = !(busy[rs1] | busy[rs2] | (issue_rd_en_i & busy[rd])), using registered busy only; no same-cycle clear bypass.
REQ-014 SHALL define issue fire = issue_valid_i & issue_ready_o; on fire with issue_rd_en_i and rd != 0, busy[rd] sets at the next edge.
REQ-015 SHALL arbitrate the two writeback channels round-robin, state LAST_ALU / LAST_LSU: single requester always granted; both requesting -> grant the channel not last granted.
REQ-016 SHALL update arbiter state only on a grant; drive *_wb_ready_o combinationally = grant; grant independent of issue signals.
REQ-017 SHALL register the granted writeback: rf_wen_o, rf_addr_wd_o, rf_wd_o valid exactly one cycle after the accepting handshake; rf_wen_o = 0 in cycles with no grant.
REQ-018 SHALL accept writeback to address 0 (handshake completes) but keep rf_wen_o = 0 for it.
REQ-019 SHALL clear busy[addr] at the edge ending the accepting cycle.
REQ-020 SHALL, if set and clear target the same register on one edge, resolve set wins.
REQ-021 SHALL pulse wb_err_o for one cycle, one cycle after accepting a nonzero-address writeback whose busy bit was 0; the write is still performed.
REQ-022 SHALL, on flush_i, clear all busy bits at the next edge, overriding same-cycle sets; writebacks accepted in that cycle still reach the bank, and wb_err_o is suppressed for them.

Reset
REQ-023 SHALL, while rst is high at a clock edge, clear busy to all 0, rf_wen_o/rf_addr_wd_o/rf_wd_o to 0, wb_err_o to 0, arbiter state to LAST_LSU (ALU first).
REQ-024 SHALL discard any handshake in progress when reset is asserted mid-operation; no bank write results from it.

Structure
REQ-025 SHALL take ADDR_WIDTH, WORD_WIDTH, N_OF_REGS defaults and the arbiter state enum from the shared package riscv_defines.
REQ-026 SHALL implement the two-way round-robin as sub-module wb_rr_arbiter (valid pair in, grant pair out, state internal).

Verification
REQ-027 SHALL cover: issue rd=5 rd_en=1 -> busy_o[5]=1 next cycle; later issue rs1=5 -> issue_ready_o=0 until ALU wb addr=5 accepted, then 1 the following cycle.
REQ-028 SHALL cover: ALU and LSU valid together for 4 cycles from reset -> grants ALU,LSU,ALU,LSU; rf_addr_wd_o follows one cycle later.
REQ-029 SHALL cover: LSU wb addr=0 data=0xDEADBEEF -> lsu_wb_ready_o=1, rf_wen_o stays 0, wb_err_o=0.
REQ-030 SHALL cover: ALU wb addr=7 with busy[7]=0 -> rf_wen_o=1 addr 7 and wb_err_o=1 next cycle.
REQ-031 SHALL cover: busy[3],[9] set, flush_i with same-cycle issue rd=12 -> busy_o all 0 next cycle.
REQ-032 SHALL cover: rst high during accepted ALU wb addr=4 -> rf_wen_o=0 and busy_o=0 next cycle.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared definitions for the register-file scoreboard and writeback arbitration.
package riscv_defines;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_N_OF_REGS  = 32;

    // Which writeback channel received the most recent grant.
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_LSU = 1'b1
    } wb_arb_state_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter between the ALU (bit 0) and LSU (bit 1)
// writeback channels. After reset the ALU channel has priority.
module wb_rr_arbiter
    import riscv_defines::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    wb_arb_state_e r_state;
    wb_arb_state_e w_state_next;

    // Grant selection and state advance; state only moves when something is granted.
    always_comb begin
        o_grant      = 2'b00;
        w_state_next = r_state;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_state == LAST_LSU) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
        if (o_grant[0]) begin
            w_state_next = LAST_ALU;
        end else if (o_grant[1]) begin
            w_state_next = LAST_LSU;
        end else begin
            w_state_next = r_state;
        end
    end

    // Round-robin state register; reset leaves LSU as "last" so ALU wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LAST_LSU;
        end else begin
            r_state <= w_state_next;
        end
    end

endmodule

// File: rtl/rf_scoreboard_ctrl.sv
// Register-file scoreboard: tracks pending destination registers, stalls
// issue on hazards, and funnels two writeback channels into one bank port.
module rf_scoreboard_ctrl
    import riscv_defines::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int N_OF_REGS  = DEF_N_OF_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_rs1_i,
    input  logic [ADDR_WIDTH-1:0] issue_rs2_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    input  logic                  issue_rd_en_i,
    output logic                  issue_ready_o,
    input  logic                  alu_wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_wb_addr_i,
    input  logic [WORD_WIDTH-1:0] alu_wb_data_i,
    output logic                  alu_wb_ready_o,
    input  logic                  lsu_wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_wb_addr_i,
    input  logic [WORD_WIDTH-1:0] lsu_wb_data_i,
    output logic                  lsu_wb_ready_o,
    output logic                  rf_wen_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_wd_o,
    output logic [WORD_WIDTH-1:0] rf_wd_o,
    input  logic                  flush_i,
    output logic [N_OF_REGS-1:0]  busy_o,
    output logic                  wb_err_o
);

    logic [N_OF_REGS-1:0]  r_busy;
    logic [N_OF_REGS-1:0]  w_busy_next;
    logic [N_OF_REGS-1:0]  w_set_vec;
    logic [N_OF_REGS-1:0]  w_clr_vec;
    logic [1:0]            w_grant;
    logic                  w_fire;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_wb_addr;
    logic [WORD_WIDTH-1:0] w_wb_data;
    logic                  w_wb_nonzero;
    logic                  w_err_next;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_data;
    logic                  r_err;

    // Hazard check looks only at registered busy bits, so a clear in this
    // same cycle does not release the stall until the next one.
    assign issue_ready_o = ~(r_busy[issue_rs1_i] | r_busy[issue_rs2_i] |
                             (issue_rd_en_i & r_busy[issue_rd_i]));
    assign w_fire        = issue_valid_i & issue_ready_o;

    wb_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_valid ({lsu_wb_valid_i, alu_wb_valid_i}),
        .o_grant (w_grant)
    );

    assign alu_wb_ready_o = w_grant[0];
    assign lsu_wb_ready_o = w_grant[1];
    assign w_accept       = w_grant[0] | w_grant[1];

    // Mux the granted channel's address and data.
    always_comb begin
        w_wb_addr = {ADDR_WIDTH{1'b0}};
        w_wb_data = {WORD_WIDTH{1'b0}};
        if (w_grant[0]) begin
            w_wb_addr = alu_wb_addr_i;
            w_wb_data = alu_wb_data_i;
        end else if (w_grant[1]) begin
            w_wb_addr = lsu_wb_addr_i;
            w_wb_data = lsu_wb_data_i;
        end else begin
            w_wb_addr = {ADDR_WIDTH{1'b0}};
            w_wb_data = {WORD_WIDTH{1'b0}};
        end
    end

    assign w_wb_nonzero = (w_wb_addr != {ADDR_WIDTH{1'b0}});
    // A flush wipes the scoreboard, so a "not busy" writeback is then expected.
    assign w_err_next   = w_accept & w_wb_nonzero & ~r_busy[w_wb_addr] & ~flush_i;

    // Next busy state: clear on writeback, set on issue (set wins), flush clears all.
    always_comb begin
        w_set_vec   = {N_OF_REGS{1'b0}};
        w_clr_vec   = {N_OF_REGS{1'b0}};
        w_busy_next = r_busy;
        for (int i = 1; i < N_OF_REGS; i++) begin
            w_set_vec[i] = w_fire & issue_rd_en_i & (issue_rd_i == ADDR_WIDTH'(i));
            w_clr_vec[i] = w_accept & (w_wb_addr == ADDR_WIDTH'(i));
        end
        if (flush_i) begin
            w_busy_next = {N_OF_REGS{1'b0}};
        end else begin
            w_busy_next = (r_busy & ~w_clr_vec) | w_set_vec;
        end
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard state and registered bank-write / error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= {N_OF_REGS{1'b0}};
            r_wen  <= 1'b0;
            r_addr <= {ADDR_WIDTH{1'b0}};
            r_data <= {WORD_WIDTH{1'b0}};
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_wen  <= w_accept & w_wb_nonzero;
            r_err  <= w_err_next;
            if (w_accept) begin
                r_addr <= w_wb_addr;
                r_data <= w_wb_data;
            end else begin
                r_addr <= r_addr;
                r_data <= r_data;
            end
        end
    end

    assign busy_o       = r_busy;
    assign rf_wen_o     = r_wen;
    assign rf_addr_wd_o = r_addr;
    assign rf_wd_o      = r_data;
    assign wb_err_o     = r_err;

endmodule

// File: tb/tb_rf_scoreboard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a behavioural model of the scoreboard rules.
module tb_rf_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_i, issue_rd_en_i, issue_ready_o;
    logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i;
    logic        alu_wb_valid_i, alu_wb_ready_o;
    logic [4:0]  alu_wb_addr_i;
    logic [31:0] alu_wb_data_i;
    logic        lsu_wb_valid_i, lsu_wb_ready_o;
    logic [4:0]  lsu_wb_addr_i;
    logic [31:0] lsu_wb_data_i;
    logic        rf_wen_o;
    logic [4:0]  rf_addr_wd_o;
    logic [31:0] rf_wd_o;
    logic        flush_i;
    logic [31:0] busy_o;
    logic        wb_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    bit          m_busy [32];
    bit          m_prefer_lsu;   // 1 when ALU was granted most recently
    bit          m_wen, m_err;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    rf_scoreboard_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_rd_i(issue_rd_i), .issue_rd_en_i(issue_rd_en_i), .issue_ready_o(issue_ready_o),
        .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_addr_i(alu_wb_addr_i),
        .alu_wb_data_i(alu_wb_data_i), .alu_wb_ready_o(alu_wb_ready_o),
        .lsu_wb_valid_i(lsu_wb_valid_i), .lsu_wb_addr_i(lsu_wb_addr_i),
        .lsu_wb_data_i(lsu_wb_data_i), .lsu_wb_ready_o(lsu_wb_ready_o),
        .rf_wen_o(rf_wen_o), .rf_addr_wd_o(rf_addr_wd_o), .rf_wd_o(rf_wd_o),
        .flush_i(flush_i), .busy_o(busy_o), .wb_err_o(wb_err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_prefer_lsu = 1'b0;
        m_wen = 1'b0; m_err = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    endtask

    task automatic idle();
        rst = 1'b0; flush_i = 1'b0;
        issue_valid_i = 1'b0; issue_rd_en_i = 1'b0;
        issue_rs1_i = 5'd0; issue_rs2_i = 5'd0; issue_rd_i = 5'd0;
        alu_wb_valid_i = 1'b0; alu_wb_addr_i = 5'd0; alu_wb_data_i = 32'd0;
        lsu_wb_valid_i = 1'b0; lsu_wb_addr_i = 5'd0; lsu_wb_data_i = 32'd0;
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic do_cycle();
        bit          rdy, g_alu, g_lsu, acc, fire;
        logic [4:0]  a;
        logic [31:0] d;
        #1;
        rdy = !(m_busy[issue_rs1_i] || m_busy[issue_rs2_i] ||
                (issue_rd_en_i && m_busy[issue_rd_i]));
        if (alu_wb_valid_i && lsu_wb_valid_i) g_alu = !m_prefer_lsu;
        else                                  g_alu = alu_wb_valid_i;
        g_lsu = lsu_wb_valid_i && !g_alu;
        check("issue_ready", issue_ready_o, rdy);
        check("alu_ready", alu_wb_ready_o, g_alu);
        check("lsu_ready", lsu_wb_ready_o, g_lsu);
        acc  = g_alu || g_lsu;
        a    = g_alu ? alu_wb_addr_i : lsu_wb_addr_i;
        d    = g_alu ? alu_wb_data_i : lsu_wb_data_i;
        fire = issue_valid_i && rdy;
        if (rst) begin
            model_reset();
        end else begin
            m_wen = acc && (a != 5'd0);
            m_err = acc && (a != 5'd0) && !m_busy[a] && !flush_i;
            if (acc) begin m_addr = a; m_data = d; end
            if (flush_i) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (acc) m_busy[a] = 1'b0;
                if (fire && issue_rd_en_i) m_busy[issue_rd_i] = 1'b1;
            end
            m_busy[0] = 1'b0;
            if (g_alu) m_prefer_lsu = 1'b1;
            if (g_lsu) m_prefer_lsu = 1'b0;
        end
        @(posedge clk);
        #1;
        check("busy", busy_o, model_busy_vec());
        check("rf_wen", rf_wen_o, m_wen);
        check("wb_err", wb_err_o, m_err);
        if (m_wen) begin
            check("rf_addr", rf_addr_wd_o, m_addr);
            check("rf_wd", rf_wd_o, m_data);
        end
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        do_cycle();
        idle();
    endtask

    initial begin
        idle(); rst = 1'b1;
        @(posedge clk);
        do_reset();
        check("reset_busy", busy_o, 32'd0);
        check("reset_wen", rf_wen_o, 1'b0);
        check("reset_addr", rf_addr_wd_o, 5'd0);
        check("reset_wd", rf_wd_o, 32'd0);
        check("reset_err", wb_err_o, 1'b0);

        // issue rd=5, stall on rs1=5 until ALU writeback to 5 is accepted
        issue_valid_i = 1'b1; issue_rd_en_i = 1'b1; issue_rd_i = 5'd5;
        do_cycle();
        check("hz_busy5", busy_o[5], 1'b1);
        idle(); issue_valid_i = 1'b1; issue_rs1_i = 5'd5;
        do_cycle();
        #1 check("hz_stall", issue_ready_o, 1'b0);
        alu_wb_valid_i = 1'b1; alu_wb_addr_i = 5'd5; alu_wb_data_i = 32'h1234_5678;
        do_cycle();
        alu_wb_valid_i = 1'b0;
        #1 check("hz_release", issue_ready_o, 1'b1);
        do_cycle();

        // both channels valid for four cycles: ALU, LSU, ALU, LSU
        do_reset();
        alu_wb_valid_i = 1'b1; alu_wb_addr_i = 5'd10; alu_wb_data_i = 32'hA;
        lsu_wb_valid_i = 1'b1; lsu_wb_addr_i = 5'd20; lsu_wb_data_i = 32'hB;
        for (int k = 0; k < 4; k++) begin
            do_cycle();
            check("rr_addr", rf_addr_wd_o, (k % 2 == 0) ? 5'd10 : 5'd20);
        end
        idle();

        // LSU writeback to register 0
        lsu_wb_valid_i = 1'b1; lsu_wb_addr_i = 5'd0; lsu_wb_data_i = 32'hDEAD_BEEF;
        #1 check("x0_ready", lsu_wb_ready_o, 1'b1);
        do_cycle();
        check("x0_wen", rf_wen_o, 1'b0);
        check("x0_err", wb_err_o, 1'b0);
        idle();

        // ALU writeback to non-busy register 7
        do_reset();
        alu_wb_valid_i = 1'b1; alu_wb_addr_i = 5'd7; alu_wb_data_i = 32'h77;
        do_cycle();
        check("err_wen", rf_wen_o, 1'b1);
        check("err_addr", rf_addr_wd_o, 5'd7);
        check("err_flag", wb_err_o, 1'b1);
        idle();
        do_cycle();
        check("err_pulse", wb_err_o, 1'b0);

        // flush overrides same-cycle issue
        issue_valid_i = 1'b1; issue_rd_en_i = 1'b1; issue_rd_i = 5'd3; do_cycle();
        issue_rd_i = 5'd9; do_cycle();
        check("fl_pre", busy_o, 32'h0000_0208);
        issue_rd_i = 5'd12; flush_i = 1'b1; do_cycle();
        check("fl_busy", busy_o, 32'd0);
        idle();

        // reset during an accepted writeback
        issue_valid_i = 1'b1; issue_rd_en_i = 1'b1; issue_rd_i = 5'd4; do_cycle();
        idle();
        alu_wb_valid_i = 1'b1; alu_wb_addr_i = 5'd4; alu_wb_data_i = 32'h44; rst = 1'b1;
        do_cycle();
        check("rst_wen", rf_wen_o, 1'b0);
        check("rst_busy", busy_o, 32'd0);
        idle();

        // random traffic over a small register range to provoke hazards
        for (int n = 0; n < 600; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            flush_i        = ($urandom_range(0, 29) == 0);
            issue_valid_i  = $urandom_range(0, 1);
            issue_rd_en_i  = ($urandom_range(0, 3) != 0);
            issue_rs1_i    = 5'($urandom_range(0, 7));
            issue_rs2_i    = 5'($urandom_range(0, 7));
            issue_rd_i     = 5'($urandom_range(0, 7));
            alu_wb_valid_i = ($urandom_range(0, 2) == 0);
            alu_wb_addr_i  = 5'($urandom_range(0, 7));
            alu_wb_data_i  = $urandom;
            lsu_wb_valid_i = ($urandom_range(0, 2) == 0);
            lsu_wb_addr_i  = 5'($urandom_range(0, 7));
            lsu_wb_data_i  = $urandom;
            do_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
